// File: rtl/miriscv_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | miriscv_data_mem_responder: byte-enabled word RAM behind the core's data  |
// | memory port, answering via a fixed-latency, non-stalling response pipe.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module miriscv_data_mem_responder #(
  parameter int               XLEN         = 32,
  parameter int               MEM_WORDS    = 1024,
  parameter logic [XLEN-1:0]  BASE_ADDR    = 32'h0000_0000,
  parameter int               RESP_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              data_err_o
);

  localparam int              AW        = $clog2(MEM_WORDS);
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_WORDS * 4);

  logic [XLEN-1:0] offset;
  logic            in_range;
  logic [AW-1:0]   idx;

  // Subtracting the base first makes the range test a single unsigned compare.
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = (offset < MEM_BYTES);
  assign idx      = offset[AW+1:2];

  logic [XLEN-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (data_req_i && data_we_i && in_range) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (data_be_i[i]) begin
          mem[idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  logic            stg_valid [RESP_LATENCY];
  logic            stg_err   [RESP_LATENCY];
  logic [XLEN-1:0] stg_rdata [RESP_LATENCY];

  // Stage 0 loads only real requests; idle cycles shift zeros so outputs stay clean.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int k = 0; k < RESP_LATENCY; k++) begin
        stg_valid[k] <= 1'b0;
        stg_err[k]   <= 1'b0;
        stg_rdata[k] <= '0;
      end
    end else begin
      stg_valid[0] <= data_req_i;
      stg_err[0]   <= data_req_i && !in_range;
      stg_rdata[0] <= (data_req_i && !data_we_i && in_range) ? mem[idx] : '0;
      for (int k = 1; k < RESP_LATENCY; k++) begin
        stg_valid[k] <= stg_valid[k-1];
        stg_err[k]   <= stg_err[k-1];
        stg_rdata[k] <= stg_rdata[k-1];
      end
    end
  end

  assign data_rvalid_o = stg_valid[RESP_LATENCY-1];
  assign data_err_o    = stg_err[RESP_LATENCY-1];
  assign data_rdata_o  = stg_rdata[RESP_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_miriscv_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_miriscv_data_mem_responder: three responders (latency 1/3/4) on shared |
// | stimulus, scoreboarded against a word-array reference model.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_miriscv_data_mem_responder;

  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic        rv [3];
  logic        er [3];
  logic [31:0] rd [3];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct packed {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int LAT2 = 4;

  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  miriscv_data_mem_responder #(.XLEN(32), .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .RESP_LATENCY(LAT0)) u_l1 (
    .clk_i(clk), .arstn_i(arstn), .data_req_i(req), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rvalid_o(rv[0]), .data_rdata_o(rd[0]), .data_err_o(er[0]));

  miriscv_data_mem_responder #(.XLEN(32), .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .RESP_LATENCY(LAT1)) u_l3 (
    .clk_i(clk), .arstn_i(arstn), .data_req_i(req), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rvalid_o(rv[1]), .data_rdata_o(rd[1]), .data_err_o(er[1]));

  miriscv_data_mem_responder #(.XLEN(32), .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .RESP_LATENCY(LAT2)) u_l4 (
    .clk_i(clk), .arstn_i(arstn), .data_req_i(req), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rvalid_o(rv[2]), .data_rdata_o(rd[2]), .data_err_o(er[2]));

  // Reference: the memory is a plain array of words; a request is in range when
  // its byte address lies below WORDS*4 (base 0).
  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    exp_t x;
    int   wi;
    bit   inr;
    logic [31:0] word;
    inr = (a < 32'(WORDS * 4));
    wi  = int'(a / 4);
    x.err   = !inr;
    x.rdata = 32'h0;
    if (inr && !w) x.rdata = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
    if (inr && w) begin
      word = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
      for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
      ref_mem[wi] = word;
    end
    x.cyc = cyc + LAT0; q0.push_back(x);
    x.cyc = cyc + LAT1; q1.push_back(x);
    x.cyc = cyc + LAT2; q2.push_back(x);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input int d, input logic v, input logic e, input logic [31:0] r);
    exp_t x;
    bit   have;
    bit   due;
    have = 1'b0;
    due  = 1'b0;
    total++;
    if (v) begin
      case (d)
        0: if (q0.size() > 0) begin x = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin x = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        bad++;
        $display("FAIL unexpected_rvalid dut=%0d cyc=%0d got rdata=%h err=%b, required no response", d, cyc, r, e);
      end else if (x.cyc != cyc || x.rdata != r || x.err != e) begin
        bad++;
        $display("FAIL response dut=%0d got cyc=%0d rdata=%h err=%b, required cyc=%0d rdata=%h err=%b",
                 d, cyc, r, e, x.cyc, x.rdata, x.err);
      end
    end else begin
      case (d)
        0: due = (q0.size() > 0) && (q0[0].cyc <= cyc);
        1: due = (q1.size() > 0) && (q1[0].cyc <= cyc);
        default: due = (q2.size() > 0) && (q2[0].cyc <= cyc);
      endcase
      if (due) begin
        bad++;
        $display("FAIL missing_rvalid dut=%0d cyc=%0d got rvalid=0, required rvalid=1", d, cyc);
      end else if (r != 32'h0 || e != 1'b0) begin
        bad++;
        $display("FAIL idle_outputs dut=%0d cyc=%0d got rdata=%h err=%b, required rdata=0 err=0", d, cyc, r, e);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) chk(d, rv[d], er[d], rd[d]);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got no end of test, required $finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    arstn = 1'b1;
    idle(2);

    for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, 32'(i * 4), $urandom);
    idle(1);

    issue(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 4'hF, 32'h10, 32'h0);
    idle(5);

    issue(1'b1, 4'hF, 32'h20, 32'h1122_3344);
    issue(1'b1, 4'b1010, 32'h20, 32'hAA00_BB00);
    issue(1'b0, 4'h0, 32'h22, 32'h0);
    idle(5);

    for (int i = 0; i < 4; i++) issue(1'b1, 4'hF, 32'(i * 4), 32'(i + 1));
    idle(5);
    for (int i = 0; i < 4; i++) issue(1'b0, 4'hF, 32'(i * 4), 32'h0);
    idle(6);

    issue(1'b1, 4'hF, 32'h1000, 32'hCAFE_F00D);
    issue(1'b0, 4'hF, 32'h1000, 32'h0);
    issue(1'b0, 4'hF, 32'h0, 32'h0);
    idle(6);

    // Two reads in flight when reset hits: all outstanding responses are lost.
    issue(1'b1, 4'hF, 32'h14, 32'h5A5A_1234);
    idle(5);
    issue(1'b0, 4'hF, 32'h14, 32'h0);
    issue(1'b0, 4'hF, 32'h14, 32'h0);
    req = 1'b0;
    arstn = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    repeat (3) begin @(posedge clk); #1; end
    arstn = 1'b1;
    idle(6);
    issue(1'b0, 4'hF, 32'h14, 32'h0);
    idle(6);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) idle(1);
      if ($urandom_range(99) < 85) a = {26'h0, 4'($urandom_range(15)), 2'($urandom_range(3))};
      else if ($urandom_range(1) == 0) a = 32'h1000 + 32'($urandom_range(32'hFFFF));
      else a = $urandom | 32'h8000_0000;
      issue(1'($urandom_range(1)), 4'($urandom_range(15)), a, $urandom);
    end
    idle(8);

    total++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d/%0d/%0d, required 0/0/0", q0.size(), q1.size(), q2.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/miriscv_data_mem_responder.md
Name: miriscv_data_mem_responder

Overview:
Data-memory responder: the slave end of the core's data memory interface (req/we/be/addr/wdata). It accepts one request per cycle with no back-pressure, performs byte-enabled writes into an internal word-addressed RAM, and returns a read word through a fixed-latency response pipeline. It is used as the tightly-coupled data memory in the miriscv subsystem and as the bench memory model.

Parameters:
XLEN, 32, data/address width; only 32 is supported.
MEM_WORDS, 1024, RAM depth in 32-bit words; must be a power of 2, at least 4.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to MEM_WORDS*4.
RESP_LATENCY, 1, cycles from request acceptance to data_rvalid_o; legal range 1..4.

Ports:
clk_i  input  1  clock, rising edge
arstn_i  input  1  asynchronous active-low reset
data_req_i  input  1  request valid; accepted in the same cycle, no grant
data_we_i  input  1  1 = write, 0 = read
data_be_i  input  XLEN/8  byte enables; write lanes only
data_addr_i  input  XLEN  byte address; bits [1:0] ignored for indexing
data_wdata_i  input  XLEN  write data, already lane-aligned by the core
data_rvalid_o  output  1  response valid, one pulse per accepted request
data_rdata_o  output  XLEN  read data, full word; valid with data_rvalid_o
data_err_o  output  1  out-of-range access; valid with data_rvalid_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset arstn_i is asynchronous and active-low.
- Reset values: data_rvalid_o=0, data_err_o=0, data_rdata_o=0. All response pipeline stages are cleared. RAM contents are not reset.
- In range: (data_addr_i - BASE_ADDR) < MEM_WORDS*4, compared unsigned on XLEN bits. Index = offset[log2(MEM_WORDS)+1:2].
- Acceptance: every cycle with data_req_i=1 is accepted. There is no stall output.
- Write, in range: at the accepting edge, byte i of the RAM word gets data_wdata_i[8i+7:8i] for each data_be_i[i]=1. Other bytes are unchanged. be=0000 leaves the word unchanged but still produces a response.
- Read, in range: the word is sampled at the accepting edge.
- Out of range: a write has no RAM effect. A read returns 0. data_err_o=1 with the response.
- Response pipeline: RESP_LATENCY stages, each holding {valid, err, rdata}.
  - A request accepted at edge N gives data_rvalid_o=1 in the cycle after edge N+RESP_LATENCY-1. For RESP_LATENCY=1 that is the cycle directly after acceptance.
  - Responses stay in order. The pipeline never stalls. Back-to-back requests give back-to-back rvalid pulses.
- Write responses: data_rvalid_o=1, data_rdata_o=0, data_err_o=0 if in range.
- When data_rvalid_o=0: data_rdata_o=0 and data_err_o=0, driven from cleared stages.
- Read-after-write: a read accepted in any cycle after a write to the same word returns the merged new data, including a read in the immediately following cycle. Only one request exists per cycle, so there is no same-cycle hazard.
- Reset mid-operation: in-flight responses are dropped and are not replayed after reset. RAM keeps its contents.
- No X propagation on outputs: stages capture data only when the request is valid, and capture 0 otherwise.

Test Plan:
- Reset, RESP_LATENCY=1 -> rvalid/err/rdata=0 during reset and on the first cycle after release with req=0.
- Write 0xDEADBEEF to 0x10 with be=1111, then read 0x10 in the next cycle -> write rvalid with rdata=0 in cycle 1; read rvalid with rdata=0xDEADBEEF in cycle 2.
- Byte merge: word at 0x20 holds 0x11223344; write 0xAA00BB00 with be=1010; read 0x22 -> rdata=0xAA22BB44 (bits [1:0] of the address ignored).
- RESP_LATENCY=3: 4 back-to-back reads of 0x0, 0x4, 0x8, 0xC holding 1,2,3,4 -> rvalid high for 4 consecutive cycles starting 3 cycles after the first request, rdata 1,2,3,4 in order.
- Out of range with MEM_WORDS=1024, BASE_ADDR=0: write 0x1000 then read 0x1000 -> both responses have err=1, read rdata=0; word 0x0 is unchanged.
- Reset asserted with 2 reads in flight at RESP_LATENCY=4 -> no rvalid after release; a subsequent read of the written word returns its pre-reset value.
